// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: funct3 encodings,
// FSM states and small decode helpers.
package ex_muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } state_e;

    function automatic logic is_muldiv_funct7(input logic [6:0] funct7);
        return funct7 == FUNCT7_MULDIV;
    endfunction

    function automatic logic is_div_op(input logic [2:0] f3);
        return (f3 == F3_DIV) || (f3 == F3_DIVU) || (f3 == F3_REM) || (f3 == F3_REMU);
    endfunction

    function automatic logic is_signed_div(input logic [2:0] f3);
        return (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic is_rem_op(input logic [2:0] f3);
        return (f3 == F3_REM) || (f3 == F3_REMU);
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// EX <-> multiply/divide handshake: operands and strobes in, stall/done/result out.
interface ex_muldiv_if #(parameter int XLEN = 32);

    logic            start_i;
    logic [2:0]      func3_i;
    logic [XLEN-1:0] src1_i;
    logic [XLEN-1:0] src2_i;
    logic            flush_i;
    logic            stallreq_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output start_i, func3_i, src1_i, src2_i, flush_i,
        input  stallreq_o, done_o, result_o
    );

    modport slave (
        input  start_i, func3_i, src1_i, src2_i, flush_i,
        output stallreq_o, done_o, result_o
    );

endinterface

// File: rtl/ex_muldiv_div.sv
// Restoring divider datapath on unsigned magnitudes: one quotient bit per step.
module ex_muldiv_div #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quo_next,
    output logic [XLEN-1:0] rem_next,
    output logic            last_step
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  quo_q;
    logic [XLEN-1:0]  divisor_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN:0]    shifted;
    logic [XLEN-1:0]  sub;
    logic             fits;

    // The partial remainder is always below the divisor, so a subtraction
    // that fits leaves a value that needs only XLEN bits.
    always_comb begin
        shifted   = {rem_q, quo_q[XLEN-1]};
        fits      = shifted >= {1'b0, divisor_q};
        sub       = shifted[XLEN-1:0] - divisor_q;
        rem_next  = fits ? sub : shifted[XLEN-1:0];
        quo_next  = {quo_q[XLEN-2:0], fits};
        last_step = cnt_q == CNT_W'(XLEN - 1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
        end else if (load) begin
            rem_q     <= '0;
            quo_q     <= dividend;
            divisor_q <= divisor;
            cnt_q     <= '0;
        end else if (step) begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit for EX. Optional divide-result
// cache (DIV/REM fusion) enabled by defining EX_MULDIV_REMFUSE_EN.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN       = XLEN_DEFAULT,
    parameter int MUL_UNROLL = 4
) (
    input  logic         clk,
    input  logic         rst,
    ex_muldiv_if.slave   bus
);

    localparam int MUL_STEPS = XLEN / MUL_UNROLL;
    localparam int CNT_W     = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state_q, state_d;
    logic [2:0]        func3_q;
    logic [XLEN-1:0]   result_q;
    logic [2*XLEN-1:0] acc_q, mcand_q, acc_step, product;
    logic [XLEN-1:0]   mplier_q, mul_res;
    logic [CNT_W-1:0]  mul_cnt_q;
    logic              sign_q, a_neg_q, mul_last;

    logic [2:0]        f3;
    logic [XLEN-1:0]   a, b, a_mag, b_mag;
    logic              accept, div_op, div_signed, a_neg, b_neg;
    logic              special, fast, stall, done;
    logic [XLEN-1:0]   special_res, fast_res;

    logic [XLEN-1:0]   quo_next, rem_next, quo_fix, rem_fix, div_res;
    logic              div_last;

    assign f3 = bus.func3_i;
    assign a  = bus.src1_i;
    assign b  = bus.src2_i;

    // Decode of the presented op: operand magnitudes and the one-cycle
    // divide corner cases (divide by zero, signed overflow).
    always_comb begin
        accept     = (state_q == ST_IDLE) && bus.start_i && !bus.flush_i;
        div_op     = is_div_op(f3);
        div_signed = is_signed_div(f3);
        if (div_op) begin
            a_neg = div_signed && a[XLEN-1];
            b_neg = div_signed && b[XLEN-1];
        end else begin
            a_neg = ((f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU)) && a[XLEN-1];
            b_neg = ((f3 == F3_MUL) || (f3 == F3_MULH)) && b[XLEN-1];
        end
        a_mag   = a_neg ? -a : a;
        b_mag   = b_neg ? -b : b;
        special = div_op && ((b == '0) || (div_signed && (a == MOST_NEG) && (b == '1)));
        if (b == '0) begin
            special_res = is_rem_op(f3) ? a : '1;
        end else begin
            special_res = is_rem_op(f3) ? '0 : a;
        end
    end

`ifdef EX_MULDIV_REMFUSE_EN
    logic            cache_valid_q, cache_signed_q, cache_hit;
    logic [XLEN-1:0] cache_a_q, cache_b_q, cache_quo_q, cache_rem_q;
    logic [XLEN-1:0] src1_q, src2_q, cache_res;

    always_comb begin
        cache_hit = div_op && cache_valid_q && (cache_a_q == a) && (cache_b_q == b)
                    && (cache_signed_q == div_signed);
        cache_res = is_rem_op(f3) ? cache_rem_q : cache_quo_q;
    end

    // Remember the operands and both results of the last full divide so a
    // matching DIV/REM pair only pays the long latency once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cache_valid_q  <= 1'b0;
            cache_signed_q <= 1'b0;
            cache_a_q      <= '0;
            cache_b_q      <= '0;
            cache_quo_q    <= '0;
            cache_rem_q    <= '0;
            src1_q         <= '0;
            src2_q         <= '0;
        end else if (bus.flush_i) begin
            cache_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                src1_q <= a;
                src2_q <= b;
            end
            if ((state_q == ST_DIV) && div_last) begin
                cache_valid_q  <= 1'b1;
                cache_signed_q <= is_signed_div(func3_q);
                cache_a_q      <= src1_q;
                cache_b_q      <= src2_q;
                cache_quo_q    <= quo_fix;
                cache_rem_q    <= rem_fix;
            end
        end
    end
`endif

    always_comb begin
        fast     = special;
        fast_res = special_res;
`ifdef EX_MULDIV_REMFUSE_EN
        if (!special && cache_hit) begin
            fast     = 1'b1;
            fast_res = cache_res;
        end
`endif
    end

    // Retire MUL_UNROLL multiplier bits per cycle into the 2*XLEN accumulator.
    always_comb begin
        acc_step = acc_q;
        for (int i = 0; i < MUL_UNROLL; i++) begin
            if (mplier_q[i]) begin
                acc_step = acc_step + (mcand_q << i);
            end
        end
        product  = sign_q ? -acc_step : acc_step;
        mul_res  = (func3_q == F3_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
        mul_last = mul_cnt_q == CNT_W'(MUL_STEPS - 1);
        quo_fix  = sign_q ? -quo_next : quo_next;
        rem_fix  = a_neg_q ? -rem_next : rem_next;
        div_res  = is_rem_op(func3_q) ? rem_fix : quo_fix;
    end

    ex_muldiv_div #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .rst       (rst),
        .load      (accept && div_op && !fast),
        .step      ((state_q == ST_DIV) && !bus.flush_i),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quo_next  (quo_next),
        .rem_next  (rem_next),
        .last_step (div_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stall = accept;
                if (accept) begin
                    state_d = fast ? ST_DONE : (div_op ? ST_DIV : ST_MUL);
                end
            end
            ST_MUL: begin
                stall = 1'b1;
                if (bus.flush_i)   state_d = ST_IDLE;
                else if (mul_last) state_d = ST_DONE;
            end
            ST_DIV: begin
                stall = 1'b1;
                if (bus.flush_i)   state_d = ST_IDLE;
                else if (div_last) state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            func3_q   <= '0;
            result_q  <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            mul_cnt_q <= '0;
            sign_q    <= 1'b0;
            a_neg_q   <= 1'b0;
        end else if (accept) begin
            func3_q   <= f3;
            acc_q     <= '0;
            mcand_q   <= {{XLEN{1'b0}}, a_mag};
            mplier_q  <= b_mag;
            mul_cnt_q <= '0;
            sign_q    <= a_neg ^ b_neg;
            a_neg_q   <= a_neg;
            if (fast) begin
                result_q <= fast_res;
            end
        end else if ((state_q == ST_MUL) && !bus.flush_i) begin
            acc_q     <= acc_step;
            mcand_q   <= mcand_q << MUL_UNROLL;
            mplier_q  <= mplier_q >> MUL_UNROLL;
            mul_cnt_q <= mul_cnt_q + 1'b1;
            if (mul_last) begin
                result_q <= mul_res;
            end
        end else if ((state_q == ST_DIV) && !bus.flush_i && div_last) begin
            result_q <= div_res;
        end
    end

    // Stall is forced low while reset is held so ctrl never sees a stale request.
    assign bus.stallreq_o = stall && rst;
    assign bus.done_o     = done;
    assign bus.result_o   = result_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv (XLEN=32, MUL_UNROLL=4) with a result/latency scoreboard.
module tb_ex_muldiv;

    typedef struct {
        string       tag;
        logic [31:0] res;
        int          lat;
    } exp_t;

`ifdef EX_MULDIV_REMFUSE_EN
    localparam bit FUSE = 1'b1;
`else
    localparam bit FUSE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];

    logic        cache_valid = 1'b0;
    logic        cache_signed = 1'b0;
    logic [31:0] cache_a = '0;
    logic [31:0] cache_b = '0;
    logic [31:0] last_result = '0;

    always #5 clk = ~clk;

    ex_muldiv_if #(.XLEN(32)) bus ();

    ex_muldiv #(.XLEN(32), .MUL_UNROLL(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        int          ia = $signed(a);
        int          ib = $signed(b);
        logic [63:0] p;
        logic [31:0] r;
        case (f3)
            3'd0: begin p = 64'(sa * sb); r = p[31:0]; end
            3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
            3'd2: begin p = 64'(sa * longint'({32'b0, b})); r = p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
            3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ((a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(ia / ib));
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 0) ? a : ((a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(ia % ib));
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic sgn = ~f3[0];
        if (!f3[2]) return 9;
        if (b == 0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
        if (FUSE && cache_valid && cache_a == a && cache_b == b && cache_signed == sgn) return 1;
        cache_valid  = 1'b1;
        cache_a      = a;
        cache_b      = b;
        cache_signed = sgn;
        return 33;
    endfunction

    task automatic check_output(input int cyc);
        exp_t e;
        e = sb_q.pop_front();
        check({e.tag, "_done"}, 64'(bus.done_o), 64'd1);
        check({e.tag, "_res"}, 64'(bus.result_o), 64'(e.res));
        check({e.tag, "_lat"}, 64'(cyc), 64'(e.lat));
        check({e.tag, "_stall_done"}, 64'(bus.stallreq_o), 64'd0);
        last_result = e.res;
    endtask

    // Called just after a falling edge with the DUT idle; returns one falling edge past done.
    task automatic apply_stimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                  input string tag);
        exp_t e;
        int   cyc;
        e.tag = tag;
        e.res = model(f3, a, b);
        e.lat = latency(f3, a, b);
        sb_q.push_back(e);
        bus.func3_i = f3;
        bus.src1_i  = a;
        bus.src2_i  = b;
        bus.start_i = 1'b1;
        #1 check({tag, "_stall0"}, 64'(bus.stallreq_o), 64'd1);
        @(negedge clk);
        bus.start_i = 1'b0;
        cyc = 1;
        while (!bus.done_o && cyc < 80) begin
            check({tag, "_stall_busy"}, 64'(bus.stallreq_o), 64'd1);
            @(negedge clk);
            cyc++;
        end
        check_output(cyc);
        @(negedge clk);
    endtask

    initial begin
        logic saw_done;
        bus.start_i = 1'b1;
        bus.flush_i = 1'b0;
        bus.func3_i = 3'd0;
        bus.src1_i  = 32'd1;
        bus.src2_i  = 32'd1;

        repeat (2) @(negedge clk);
        #1;
        check("rst_stall", 64'(bus.stallreq_o), 64'd0);
        check("rst_done", 64'(bus.done_o), 64'd0);
        check("rst_result", 64'(bus.result_o), 64'd0);
        bus.start_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        apply_stimulus(3'd0, 32'd7, 32'hFFFF_FFFD, "mul_7_m3");
        apply_stimulus(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max");
        apply_stimulus(3'd1, 32'h8000_0000, 32'h8000_0000, "mulh_min");
        apply_stimulus(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1");
        apply_stimulus(3'd4, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        apply_stimulus(3'd6, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
        apply_stimulus(3'd5, 32'd100, 32'd7, "divu_100_7");
        apply_stimulus(3'd7, 32'd100, 32'd7, "remu_100_7");
        apply_stimulus(3'd4, 32'd100, 32'd7, "div_100_7");
        apply_stimulus(3'd6, 32'd100, 32'd7, "rem_100_7");
        apply_stimulus(3'd6, 32'd100, 32'd9, "rem_100_9");
        apply_stimulus(3'd4, 32'd5, 32'd0, "div_by0");
        apply_stimulus(3'd6, 32'd5, 32'd0, "rem_by0");
        apply_stimulus(3'd5, 32'd5, 32'd0, "divu_by0");
        apply_stimulus(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        apply_stimulus(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(3'($urandom_range(0, 7)), 32'($urandom), 32'($urandom_range(1, 1000)), "rand");
        end

        // start together with flush in IDLE must be dropped
        bus.func3_i = 3'd0;
        bus.src1_i  = 32'd3;
        bus.src2_i  = 32'd3;
        bus.start_i = 1'b1;
        bus.flush_i = 1'b1;
        #1 check("flush_start_stall", 64'(bus.stallreq_o), 64'd0);
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        cache_valid = 1'b0;
        #1;
        check("flush_start_idle_stall", 64'(bus.stallreq_o), 64'd0);
        check("flush_start_idle_done", 64'(bus.done_o), 64'd0);
        @(negedge clk);

        // DIV aborted by flush at cycle 10
        bus.func3_i = 3'd4;
        bus.src1_i  = 32'd100;
        bus.src2_i  = 32'd7;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        saw_done = 1'b0;
        for (int c = 1; c < 10; c++) begin
            if (bus.done_o) saw_done = 1'b1;
            @(negedge clk);
        end
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        cache_valid = 1'b0;
        #1;
        check("flush_no_done", 64'(saw_done | bus.done_o), 64'd0);
        check("flush_idle_stall", 64'(bus.stallreq_o), 64'd0);
        check("flush_result_held", 64'(bus.result_o), 64'(last_result));
        apply_stimulus(3'd0, 32'd12345, 32'd678, "mul_after_flush");
        apply_stimulus(3'd6, 32'd100, 32'd7, "rem_after_flush");

        // reset pulsed in the middle of a divide
        bus.func3_i = 3'd5;
        bus.src1_i  = 32'd1000;
        bus.src2_i  = 32'd3;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        bus.start_i = 1'b1;
        #1;
        check("midrst_stall", 64'(bus.stallreq_o), 64'd0);
        check("midrst_done", 64'(bus.done_o), 64'd0);
        check("midrst_result", 64'(bus.result_o), 64'd0);
        @(negedge clk);
        bus.start_i = 1'b0;
        rst = 1'b1;
        cache_valid = 1'b0;
        last_result = '0;
        #1;
        check("postrst_done", 64'(bus.done_o), 64'd0);
        check("postrst_result", 64'(bus.result_o), 64'd0);
        @(negedge clk);
        apply_stimulus(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, "mulhu_postrst");
        apply_stimulus(3'd7, 32'd1000, 32'd3, "remu_postrst");

        $display("[TB] all directed steps issued");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
